// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types for the single-port RAM arbiter.
// Requester ids, read-tracking stage record and the read-latency ceiling.
package ram_arb_pkg;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t owner;
  } track_t;

  localparam int MAX_RD_LAT = 3;

endpackage

// File: rtl/ram_arb_rr.sv
// ram_arb_rr: two-way round-robin grant picker (bit0 = A, bit1 = B).
// Ports: req_i, last_gnt_i (side granted most recently) in; gnt_o out.
// RAM_ARB_PRIO_A_EN: A has strict priority and last_gnt_i is ignored.
module ram_arb_rr
  import ram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_t    last_gnt_i,
  output logic [1:0] gnt_o
);

`ifdef RAM_ARB_PRIO_A_EN
  logic unused_last;
  assign unused_last = last_gnt_i;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0]) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
  end
`else
  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // contention: the side that did not win last time goes now
      2'b11:   gnt_o = (last_gnt_i == REQ_B) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/ram_1port_arbiter.sv
// ram_1port_arbiter: shares one single-port RAM between requesters A and B.
// Ports: a_*/b_* request/grant/read-return per side, ram_* to the RAM,
// sys_clk/sys_rst (async active-high). RAM_ARB_PRIO_A_EN: A strict priority.
module ram_1port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data
);

  if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_lat
    $error("ram_1port_arbiter: RD_LAT out of range");
  end

  logic [1:0]        req;
  logic [1:0]        gnt_raw;
  logic [1:0]        gnt;
  req_id_t           last_gnt_q;
  track_t            pipe_d;
  track_t            pipe_q [RD_LAT];
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;
  track_t            tail;

  assign req = {b_req, a_req};

  ram_arb_rr u_rr (
    .req_i      (req),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (gnt_raw)
  );

  // grants are combinational, so reset must mask them directly
  assign gnt   = gnt_raw & {2{~sys_rst}};
  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];

  always_comb begin
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wr_data = '0;
    unique case (1'b1)
      gnt[0]: begin
        ram_en      = 1'b1;
        ram_we      = a_we;
        ram_addr    = a_addr;
        ram_wr_data = a_wdata;
      end
      gnt[1]: begin
        ram_en      = 1'b1;
        ram_we      = b_we;
        ram_addr    = b_addr;
        ram_wr_data = b_wdata;
      end
      default: ;
    endcase
  end

`ifdef RAM_ARB_PRIO_A_EN
  assign last_gnt_q = REQ_B;
`else
  req_id_t last_gnt_d;

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt[0]) begin
      last_gnt_d = REQ_A;
    end else if (gnt[1]) begin
      last_gnt_d = REQ_B;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      last_gnt_q <= REQ_B;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`endif

  // one stage per cycle of RAM latency; the tail lines up with rd_data
  always_comb begin
    pipe_d       = '0;
    pipe_d.valid = ram_en & ~ram_we;
    pipe_d.owner = gnt[1] ? REQ_B : REQ_A;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= pipe_d;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tail     = pipe_q[RD_LAT-1];
  assign a_rvalid = tail.valid & (tail.owner == REQ_A);
  assign b_rvalid = tail.valid & (tail.owner == REQ_B);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_rvalid) a_rdata_q <= ram_rd_data;
      if (b_rvalid) b_rdata_q <= ram_rd_data;
    end
  end

  // live RAM data on the rvalid cycle, the captured copy afterwards
  assign a_rdata = a_rvalid ? ram_rd_data : a_rdata_q;
  assign b_rdata = b_rvalid ? ram_rd_data : b_rdata_q;

endmodule

// File: tb/tb_ram_1port_arbiter.sv
// tb_ram_1port_arbiter: checks two arbiter instances (RD_LAT 1 and 2)
// against a reference grant model, shadow memory and read scoreboards.
module tb_ram_1port_arbiter;

`ifdef RAM_ARB_PRIO_A_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [4:0] a_addr = 0, b_addr = 0;
  logic [7:0] a_wdata = 0, b_wdata = 0;

  logic       a_gnt1, b_gnt1, a_rv1, b_rv1, r1_en, r1_we;
  logic [7:0] a_rd1, b_rd1, r1_wd, r1_rd;
  logic [4:0] r1_addr;
  logic       a_gnt2, b_gnt2, a_rv2, b_rv2, r2_en, r2_we;
  logic [7:0] a_rd2, b_rd2, r2_wd, r2_rd;
  logic [4:0] r2_addr;

  ram_1port_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1)) u1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt1), .a_rvalid(a_rv1), .a_rdata(a_rd1),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt1), .b_rvalid(b_rv1), .b_rdata(b_rd1),
    .ram_en(r1_en), .ram_we(r1_we), .ram_addr(r1_addr),
    .ram_wr_data(r1_wd), .ram_rd_data(r1_rd)
  );

  ram_1port_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LAT(2)) u2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt2), .a_rvalid(a_rv2), .a_rdata(a_rd2),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt2), .b_rvalid(b_rv2), .b_rdata(b_rd2),
    .ram_en(r2_en), .ram_we(r2_we), .ram_addr(r2_addr),
    .ram_wr_data(r2_wd), .ram_rd_data(r2_rd)
  );

  // RAM models: latency 1 and latency 2
  logic [7:0] mem1 [32];
  logic [7:0] mem2 [32];
  logic [7:0] rd2_s;
  initial begin
    for (int i = 0; i < 32; i++) begin
      mem1[i] = 8'h00;
      mem2[i] = 8'h00;
    end
    r1_rd = 8'h00;
    r2_rd = 8'h00;
    rd2_s = 8'h00;
  end
  always @(posedge sys_clk) begin
    if (r1_en) begin
      if (r1_we) mem1[r1_addr] <= r1_wd;
      else       r1_rd <= mem1[r1_addr];
    end
    if (r2_en) begin
      if (r2_we) mem2[r2_addr] <= r2_wd;
      else       rd2_s <= mem2[r2_addr];
    end
    r2_rd <= rd2_s;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model state
  typedef struct {
    logic       owner;
    logic [7:0] data;
    int         cyc;
  } rd_t;
  rd_t        q1[$];
  rd_t        q2[$];
  logic       last_m = 1'b1;
  logic       ega = 1'b0, egb = 1'b0;
  logic [7:0] shadow [32];
  logic [7:0] held_a = 8'h00, held_b = 8'h00;
  int         cyc = 0;

  initial for (int i = 0; i < 32; i++) shadow[i] = 8'h00;
  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    rd_t        e;
    logic       ga, gb, xwe;
    logic [4:0] xad;
    logic [7:0] xwd;
    if (sys_rst) begin
      ega = 0; egb = 0; last_m = 1;
      held_a = 0; held_b = 0;
      q1.delete(); q2.delete();
      chk("rst_gnt", 32'({a_gnt1, b_gnt1, a_gnt2, b_gnt2}), 0);
      chk("rst_ram", 32'({r1_en, r1_we, r1_addr, r1_wd,
                          r2_en, r2_we, r2_addr}), 0);
      chk("rst_wd2", 32'(r2_wd), 0);
      chk("rst_rv", 32'({a_rv1, b_rv1, a_rv2, b_rv2}), 0);
      chk("rst_rd", {a_rd1, b_rd1, a_rd2, b_rd2}, 0);
    end else begin
      ga  = a_req && (PRIO || !b_req || last_m);
      gb  = b_req && !ga;
      xwe = ga ? a_we : (gb ? b_we : 1'b0);
      xad = ga ? a_addr : (gb ? b_addr : 5'h00);
      xwd = (ga && a_we) ? a_wdata : ((gb && b_we) ? b_wdata : 8'h00);
      chk("gnt1", 32'({a_gnt1, b_gnt1}), 32'({ga, gb}));
      chk("gnt2", 32'({a_gnt2, b_gnt2}), 32'({ga, gb}));
      chk("ram1", 32'({r1_en, r1_we, r1_addr}), 32'({ga | gb, xwe, xad}));
      chk("ram2", 32'({r2_en, r2_we, r2_addr}), 32'({ga | gb, xwe, xad}));
      if (xwe) begin
        chk("wd1", 32'(r1_wd), 32'(xwd));
        chk("wd2", 32'(r2_wd), 32'(xwd));
      end
      // latency 1 instance
      if (q1.size() > 0 && q1[0].cyc + 1 == cyc) begin
        e = q1.pop_front();
        chk("rv1", 32'({a_rv1, b_rv1}), 32'({!e.owner, e.owner}));
        chk("rd1", 32'(e.owner ? b_rd1 : a_rd1), 32'(e.data));
        if (e.owner) held_b = e.data;
        else         held_a = e.data;
      end else begin
        chk("rv1_idle", 32'({a_rv1, b_rv1}), 0);
        chk("hold_a1", 32'(a_rd1), 32'(held_a));
        chk("hold_b1", 32'(b_rd1), 32'(held_b));
      end
      // latency 2 instance
      if (q2.size() > 0 && q2[0].cyc + 2 == cyc) begin
        e = q2.pop_front();
        chk("rv2", 32'({a_rv2, b_rv2}), 32'({!e.owner, e.owner}));
        chk("rd2", 32'(e.owner ? b_rd2 : a_rd2), 32'(e.data));
      end else begin
        chk("rv2_idle", 32'({a_rv2, b_rv2}), 0);
      end
      if (ga || gb) begin
        last_m = gb;
        if (xwe) begin
          shadow[xad] = xwd;
        end else begin
          e.owner = gb;
          e.data  = shadow[xad];
          e.cyc   = cyc;
          q1.push_back(e);
          q2.push_back(e);
        end
      end
      ega = ga;
      egb = gb;
    end
  end

  task automatic drv(input logic ar, input logic aw, input logic [4:0] aa,
                     input logic [7:0] ad, input logic br, input logic bw,
                     input logic [4:0] ba, input logic [7:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  typedef struct {
    logic       ar, aw;
    logic [4:0] aa;
    logic [7:0] ad;
    logic       br, bw;
    logic [4:0] ba;
    logic [7:0] bd;
    logic       xa, xb, xrv;
    logic [7:0] xrd;
  } vec_t;
  vec_t tbl [14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ai, bi;
    // contention from reset, then B alone, write, read-back
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 1'b0, 5'h03, 8'h00, 1'b1, 1'b0, 5'h04, 8'h00,
                 PRIO ? 1'b1 : (i % 2 == 0), PRIO ? 1'b0 : (i % 2 == 1),
                 PRIO ? (i > 0) : (i % 2 == 1), 8'h00};
    tbl[8]  = '{0, 0, 5'h00, 8'h00, 1, 0, 5'h04, 8'h00, 0, 1, PRIO, 8'h00};
    tbl[9]  = '{1, 1, 5'h03, 8'h5A, 0, 0, 5'h00, 8'h00, 1, 0, 0, 8'h00};
    tbl[10] = '{0, 0, 5'h00, 8'h00, 0, 0, 5'h00, 8'h00, 0, 0, 0, 8'h00};
    tbl[11] = '{1, 0, 5'h03, 8'h00, 0, 0, 5'h00, 8'h00, 1, 0, 0, 8'h00};
    tbl[12] = '{0, 0, 5'h00, 8'h00, 0, 0, 5'h00, 8'h00, 0, 0, 1, 8'h5A};
    tbl[13] = '{0, 0, 5'h00, 8'h00, 0, 0, 5'h00, 8'h00, 0, 0, 0, 8'h5A};

    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;

    foreach (tbl[i]) begin
      @(posedge sys_clk); #1;
      drv(tbl[i].ar, tbl[i].aw, tbl[i].aa, tbl[i].ad,
          tbl[i].br, tbl[i].bw, tbl[i].ba, tbl[i].bd);
      @(negedge sys_clk);
      chk($sformatf("vec%0d_gnt", i), 32'({a_gnt1, b_gnt1}),
          32'({tbl[i].xa, tbl[i].xb}));
      chk($sformatf("vec%0d_arv", i), 32'(a_rv1), 32'(tbl[i].xrv));
      chk($sformatf("vec%0d_ard", i), 32'(a_rd1), 32'(tbl[i].xrd));
    end

    // B fills 0..31 with data=addr while A reads 31..0
    ai = 0; bi = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge sys_clk); #1;
      if (ega) ai++;
      if (egb) bi++;
      drv(ai < 32, 1'b0, 5'(31 - ai), 8'h00,
          bi < 32, 1'b1, 5'(bi), 8'(bi));
      if (ai >= 32 && bi >= 32) break;
    end
    chk("t4_done", 32'({8'(ai), 8'(bi)}), 32'({8'd32, 8'd32}));
    repeat (4) @(posedge sys_clk);
    chk("t4_q1_empty", 32'(q1.size()), 0);
    chk("t4_q2_empty", 32'(q2.size()), 0);

    // read-after-fill of a known location
    @(posedge sys_clk); #1;
    drv(1, 0, 5'h0A, 8'h00, 0, 0, 5'h00, 8'h00);
    @(posedge sys_clk); #1;
    drv(0, 0, 5'h00, 8'h00, 0, 0, 5'h00, 8'h00);
    @(negedge sys_clk);
    chk("raw_rv", 32'(a_rv1), 1);
    chk("raw_rd", 32'(a_rd1), 32'h0A);

    // reset one cycle after an A read grant, with both requesting
    @(posedge sys_clk); #1;
    drv(1, 0, 5'h0A, 8'h00, 0, 0, 5'h00, 8'h00);
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    drv(1, 0, 5'h0A, 8'h00, 1, 0, 5'h01, 8'h00);
    @(negedge sys_clk);
    chk("t5_zero", 32'({a_gnt1, a_rv1, r1_en, a_rd1}), 0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("t5_first", 32'({a_gnt1, b_gnt1}), 32'b10);
    chk("t5_no_rv2", 32'({a_rv2, b_rv2}), 0);
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    chk("t5_second", 32'({a_gnt1, b_gnt1}), PRIO ? 32'b10 : 32'b01);
    @(posedge sys_clk); #1;
    drv(0, 0, 5'h00, 8'h00, 1, 0, 5'h01, 8'h00);
    @(negedge sys_clk);
    chk("t6_b_alone", 32'({a_gnt1, b_gnt1}), 32'b01);
    @(posedge sys_clk); #1;
    drv(0, 0, 5'h00, 8'h00, 0, 0, 5'h00, 8'h00);
    repeat (4) @(posedge sys_clk);
    chk("end_q1_empty", 32'(q1.size()), 0);
    chk("end_q2_empty", 32'(q2.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
